stdcell_bist_sequencer: RTL

Wishbone-programmable built-in self-test sequencer for the standard-cell test array in the user project area. It drives the array's stimulus inputs with an incrementing exhaustive pattern and waits a programmable settle time per vector. It then samples the array's outputs and compacts them into a 32-bit MISR signature that firmware reads back. It replaces direct pad stimulus when on-chip characterization is selected.

---
 rtl/stdcell_bist_sequencer.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/stdcell_bist_sequencer.sv
// stdcell_bist_sequencer
// Wishbone-programmable BIST sequencer for the standard-cell test array.
// Drives an incrementing exhaustive pattern on stim_o. For each vector it
// waits a programmable settle time, then samples the double-flopped array
// response and folds it into a 32-bit MISR signature.
module stdcell_bist_sequencer #(
   parameter int unsigned STIM_W    = 21,
   parameter int unsigned RESP_W    = 14,
   parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
   parameter logic [31:0] MISR_SEED = 32'hFFFF_FFFF,
   parameter logic [31:0] MISR_POLY = 32'h04C1_1DB7
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              wbs_stb_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_dat_i,
   input  logic [31:0]       wbs_adr_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   output logic [STIM_W-1:0] stim_o,
   input  logic [RESP_W-1:0] resp_i,
   output logic              busy_o,
   output logic              done_irq_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2
   } state_e;

   localparam logic [2:0] REG_CTRL      = 3'd0;
   localparam logic [2:0] REG_SETTLE    = 3'd1;
   localparam logic [2:0] REG_COUNT     = 3'd2;
   localparam logic [2:0] REG_STATUS    = 3'd3;
   localparam logic [2:0] REG_SIGNATURE = 3'd4;
   localparam logic [2:0] REG_LAST_RESP = 3'd5;

   localparam logic [STIM_W-1:0] STIM_ZERO = {STIM_W{1'b0}};
   localparam logic [STIM_W-1:0] STIM_ONE  = {{(STIM_W-1){1'b0}}, 1'b1};

   // One MISR compaction step: shift left, fold in the polynomial when the
   // MSB falls out, then XOR in the (zero-extended) response word.
   function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                             input logic [31:0] data);
      logic [31:0] feedback;
      feedback = sig[31] ? MISR_POLY : 32'h0000_0000;
      return ({sig[30:0], 1'b0} ^ feedback) ^ data;
   endfunction

   // Bus-side registers
   logic              ack_q;
   logic [31:0]       dat_q;
   logic [7:0]        settle_q;
   logic [STIM_W-1:0] count_q;

   // Sequencer registers
   state_e            state_q;
   logic              busy_q;
   logic              done_q;
   logic              irq_q;
   logic [7:0]        timer_q;
   logic [STIM_W-1:0] idx_q;
   logic [STIM_W-1:0] stim_q;
   logic [31:0]       misr_q;
   logic [RESP_W-1:0] last_resp_q;

   // Response synchronizer
   logic [RESP_W-1:0] resp_meta_q;
   logic [RESP_W-1:0] resp_sync_q;

   // Combinational decode and next-state values
   logic              adr_match_s;
   logic              wb_req_s;
   logic              wr_fire_s;
   logic [2:0]        reg_idx_s;
   logic              start_s;
   logic              abort_s;
   logic              settle_wr_s;
   logic              count_wr_s;
   logic [31:0]       rd_data_s;
   logic [31:0]       resp_ext_s;
   logic [31:0]       misr_d;
   logic [STIM_W-1:0] idx_d;
   logic              last_vec_s;
   logic              unused_s;

   assign adr_match_s = (wbs_adr_i[31:5] == BASE_ADR[31:5]);
   // ack_q in the request term keeps acks from ever landing on adjacent cycles
   assign wb_req_s    = wbs_stb_i & wbs_cyc_i & adr_match_s & ~ack_q;
   assign wr_fire_s   = wb_req_s & wbs_we_i & (wbs_sel_i == 4'hF);
   assign reg_idx_s   = wbs_adr_i[4:2];

   // ABORT wins over START when both are written together
   assign abort_s     = wr_fire_s & (reg_idx_s == REG_CTRL) & wbs_dat_i[1];
   assign start_s     = wr_fire_s & (reg_idx_s == REG_CTRL) & wbs_dat_i[0] & ~wbs_dat_i[1];
   assign settle_wr_s = wr_fire_s & (reg_idx_s == REG_SETTLE) & ~busy_q;
   assign count_wr_s  = wr_fire_s & (reg_idx_s == REG_COUNT) & ~busy_q;

   assign misr_d      = misr_step(misr_q, resp_ext_s);
   assign idx_d       = idx_q + STIM_ONE;
   assign last_vec_s  = (idx_q == (count_q - STIM_ONE));

   assign unused_s    = ^{wbs_adr_i[1:0], wbs_dat_i};

   // Zero-extend the synchronized response to the MISR width
   always_comb begin
      resp_ext_s = 32'h0000_0000;
      resp_ext_s[RESP_W-1:0] = resp_sync_q;
   end

   // Register read multiplexer; unmapped and write-only offsets read 0
   always_comb begin
      rd_data_s = 32'h0000_0000;
      case (reg_idx_s)
         REG_SETTLE:    rd_data_s[7:0]        = settle_q;
         REG_COUNT:     rd_data_s[STIM_W-1:0] = count_q;
         REG_STATUS:    rd_data_s[1:0]        = {done_q, busy_q};
         REG_SIGNATURE: rd_data_s             = misr_q;
         REG_LAST_RESP: rd_data_s[RESP_W-1:0] = last_resp_q;
         default:       rd_data_s             = 32'h0000_0000;
      endcase
   end

   // Wishbone acknowledge and registered read data (zero outside ack)
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         ack_q <= 1'b0;
         dat_q <= 32'h0000_0000;
      end else begin
         ack_q <= wb_req_s;
         if (wb_req_s && !wbs_we_i) begin
            dat_q <= rd_data_s;
         end else begin
            dat_q <= 32'h0000_0000;
         end
      end
   end

   // SETTLE and COUNT configuration registers, frozen while a run is active
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         settle_q <= 8'h00;
         count_q  <= STIM_ZERO;
      end else begin
         if (settle_wr_s) begin
            settle_q <= wbs_dat_i[7:0];
         end
         if (count_wr_s) begin
            count_q <= wbs_dat_i[STIM_W-1:0];
         end
      end
   end

   // Two-flop synchronizer for the asynchronous array response
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         resp_meta_q <= {RESP_W{1'b0}};
         resp_sync_q <= {RESP_W{1'b0}};
      end else begin
         resp_meta_q <= resp_i;
         resp_sync_q <= resp_meta_q;
      end
   end

   // Sequencer FSM with its datapath and registered status/irq outputs
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         irq_q       <= 1'b0;
         timer_q     <= 8'h00;
         idx_q       <= STIM_ZERO;
         stim_q      <= STIM_ZERO;
         misr_q      <= MISR_SEED;
         last_resp_q <= {RESP_W{1'b0}};
      end else begin
         irq_q <= 1'b0;
         if (abort_s) begin
            // Abandon the run: no done, no irq, signature and last response hold
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start_s) begin
                     done_q  <= 1'b0;
                     stim_q  <= STIM_ZERO;
                     idx_q   <= STIM_ZERO;
                     misr_q  <= MISR_SEED;
                     timer_q <= settle_q;
                     if (count_q == STIM_ZERO) begin
                        // Empty run completes on the START edge itself
                        done_q <= 1'b1;
                        irq_q  <= 1'b1;
                     end else begin
                        state_q <= ST_SETTLE;
                        busy_q  <= 1'b1;
                     end
                  end
               end
               ST_SETTLE: begin
                  if (timer_q == 8'h00) begin
                     state_q <= ST_SAMPLE;
                  end else begin
                     timer_q <= timer_q - 8'h01;
                  end
               end
               ST_SAMPLE: begin
                  misr_q      <= misr_d;
                  last_resp_q <= resp_sync_q;
                  if (last_vec_s) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     irq_q   <= 1'b1;
                  end else begin
                     idx_q   <= idx_d;
                     stim_q  <= idx_d;
                     timer_q <= settle_q;
                     state_q <= ST_SETTLE;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign wbs_ack_o  = ack_q;
   assign wbs_dat_o  = dat_q;
   assign stim_o     = stim_q;
   assign busy_o     = busy_q;
   assign done_irq_o = irq_q;

endmodule
